bp_cfg_init_loader: RTL and testbench
=====================================

BP_CFG_INIT_LOADER -- requirements
Module: bp_cfg_init_loader

Interface
REQ-001 The block SHALL have parameter bp_params_p, default e_bp_single_core_cfg, which selects the processor configuration; the block derives num_core = cc_x_dim*cc_y_dim from that configuration.
REQ-002 The block SHALL have parameter max_credits_p, default 4, giving the maximum number of outstanding (unacknowledged) config writes; legal range is 1..15.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 The block SHALL have port reset_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port cfg_v_o, output, 1 bit: config write valid.
REQ-006 The block SHALL have port cfg_ready_i, input, 1 bit: consumer accepts the write.
REQ-007 The block SHALL have port cfg_core_o, output, core_id_width bits: target core, where core_id_width = max(1, clog2(num_core)).
REQ-008 The block SHALL have port cfg_addr_o, output, 3 bits: config register, of type bp_cfg_reg_e.
REQ-009 The block SHALL have port cfg_data_o, output, 16 bits: write data.
REQ-010 The block SHALL have port cfg_ack_v_i, input, 1 bit: one write acknowledged (a one-cycle pulse).
REQ-011 The block SHALL have port done_o, output, 1 bit: the full sequence is issued and acknowledged.
REQ-012 The block SHALL have port err_o, output, 1 bit: sticky error, set on an ack arriving with zero credits in use.

Function
REQ-013 A write SHALL complete on a cycle with cfg_v_o & cfg_ready_i.
- While cfg_v_o=1 and cfg_ready_i=0, cfg_core_o, cfg_addr_o and cfg_data_o SHALL hold stable.
REQ-014 The FSM SHALL have states e_idle, e_send_cfg, e_send_unfreeze, e_drain, e_done.
- Reset state is e_idle.
- e_idle moves to e_send_cfg unconditionally on the first clock after reset deasserts.
REQ-015 In e_send_cfg, the block SHALL issue, for core c = 0..num_core-1 in ascending order, exactly four writes in this order:
- e_cfg_freeze, data 1
- e_cfg_core_id, data c
- e_cfg_cord, data {8'b0, y[3:0], x[3:0]}, with x = c % cc_x_dim and y = c / cc_x_dim + ic_y_dim
- e_cfg_domain, data 16'h0001
REQ-016 After the last write of core num_core-1 completes, the FSM SHALL go to e_send_unfreeze and issue e_cfg_freeze with data 0 for c = 0..num_core-1 ascending.
REQ-017 After the final unfreeze write completes, the FSM SHALL go to e_drain, and then to e_done on the cycle the credit count reaches 0.
- done_o=1 only in e_done.
- e_done is terminal until reset.
REQ-018 Credit counter (width clog2(max_credits_p+1)):
- increments on a completed write; decrements on cfg_ack_v_i.
- both in the same cycle: unchanged.
REQ-019 cfg_v_o SHALL be 0 whenever credits == max_credits_p; in that case it may rise on the cycle after an ack frees a credit.
REQ-020 cfg_ack_v_i with credits == 0 and no simultaneous completed write SHALL set err_o; the counter saturates at 0, and the FSM is otherwise unaffected.
REQ-021 Back-to-back writes SHALL be possible: with cfg_ready_i held 1 and credits available, one write completes per cycle.
REQ-022 The total write count SHALL be exactly 5*num_core; the block issues no extra writes and skips none.

Reset
REQ-023 Asserting reset_n_i low SHALL asynchronously force, regardless of any in-progress write or handshake:
- FSM state = e_idle
- core and step counters = 0
- credits = 0
- cfg_v_o = 0, done_o = 0, err_o = 0
- cfg_core_o, cfg_addr_o, cfg_data_o = 0
REQ-024 Reset deassertion after a mid-sequence reset SHALL restart the full sequence from core 0, e_cfg_freeze.

Structure
REQ-025 The enum bp_cfg_reg_e SHALL be placed in a shared package, bp_common_cfg_pkg, with values:
- e_cfg_freeze = 0
- e_cfg_core_id = 1
- e_cfg_cord = 2
- e_cfg_domain = 3
REQ-026 The cord field widths (4-bit x, 4-bit y) SHALL be defined as constants in that same package.
REQ-027 The credit counter SHALL be a single sub-module, bp_cfg_credit_counter, with inputs inc_i and dec_i and outputs count_o, full_o and underflow_o.

Verification
REQ-028 Single-core config, cfg_ready_i=1, ack one cycle after each write → 5 writes in this order:
- (0, freeze, 1)
- (0, core_id, 0)
- (0, cord, 16'h0010)
- (0, domain, 1)
- (0, freeze, 0)
- done_o rises after the last ack.
REQ-029 Quad-core config → 20 writes; the cord write for core 3 carries 16'h0021; the unfreeze writes target cores 0,1,2,3 in order.
REQ-030 max_credits_p=4, acks withheld → exactly 4 writes complete and cfg_v_o stays 0; one ack → exactly one further write.
REQ-031 cfg_ready_i toggled randomly → payload stable while stalled, sequence identical to REQ-028.
REQ-032 Spurious ack at credits=0 → err_o=1 and stays 1; sequence still completes; simultaneous write and ack leaves credits unchanged.
REQ-033 reset_n_i pulsed low mid-way through core 1 (quad-core) → all outputs 0 immediately; after release, the sequence restarts at (0, freeze, 1).

Source files
------------

// File: rtl/bp_common_cfg_pkg.sv
// Shared config-register encodings, cord field widths and processor-configuration
// helpers used by the boot-time config loader.
package bp_common_cfg_pkg;

    typedef enum logic [2:0] {
        e_cfg_freeze  = 3'd0,
        e_cfg_core_id = 3'd1,
        e_cfg_cord    = 3'd2,
        e_cfg_domain  = 3'd3
    } bp_cfg_reg_e;

    typedef enum logic [0:0] {
        e_bp_single_core_cfg = 1'b0,
        e_bp_quad_core_cfg   = 1'b1
    } bp_params_e;

    typedef enum logic [2:0] {
        e_idle          = 3'd0,
        e_send_cfg      = 3'd1,
        e_send_unfreeze = 3'd2,
        e_drain         = 3'd3,
        e_done          = 3'd4
    } bp_cfg_loader_state_e;

    localparam int cord_x_width_gp = 4;
    localparam int cord_y_width_gp = 4;

    function automatic int cfg_cc_x_dim(input bp_params_e p);
        case (p)
            e_bp_quad_core_cfg: return 2;
            default:            return 1;
        endcase
    endfunction

    function automatic int cfg_cc_y_dim(input bp_params_e p);
        case (p)
            e_bp_quad_core_cfg: return 2;
            default:            return 1;
        endcase
    endfunction

    // Compute tiles sit below one row of I/O complex tiles in every supported config.
    function automatic int cfg_ic_y_dim(input bp_params_e p);
        case (p)
            e_bp_quad_core_cfg: return 1;
            default:            return 1;
        endcase
    endfunction

    function automatic int cfg_num_core(input bp_params_e p);
        return cfg_cc_x_dim(p) * cfg_cc_y_dim(p);
    endfunction

    function automatic logic [15:0] cfg_cord_data(input bp_params_e p, input int c);
        int x;
        int y;
        logic [cord_x_width_gp-1:0] x_f;
        logic [cord_y_width_gp-1:0] y_f;
        x   = c % cfg_cc_x_dim(p);
        y   = c / cfg_cc_x_dim(p) + cfg_ic_y_dim(p);
        x_f = x[cord_x_width_gp-1:0];
        y_f = y[cord_y_width_gp-1:0];
        return {8'h00, y_f, x_f};
    endfunction

endpackage

// File: rtl/bp_cfg_credit_counter.sv
// Tracks config writes issued but not yet acknowledged; saturates at 0 and at max.
module bp_cfg_credit_counter
#(
    parameter int  max_credits_p = 4,
    localparam int width         = $clog2(max_credits_p + 1)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [width-1:0] count_o,
    output logic             full_o,
    output logic             underflow_o
);

    localparam logic [width-1:0] full_count = width'(max_credits_p);

    // Credit register: simultaneous inc and dec cancel out.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_o <= '0;
        end else if (inc_i && !dec_i && !full_o) begin
            count_o <= count_o + width'(1);
        end else if (dec_i && !inc_i && (count_o != '0)) begin
            count_o <= count_o - width'(1);
        end else begin
            count_o <= count_o;
        end
    end

    assign full_o      = (count_o == full_count);
    assign underflow_o = dec_i & ~inc_i & (count_o == '0);

endmodule

// File: rtl/bp_cfg_init_loader.sv
// Boot-time config loader: freezes, identifies and places every core, then unfreezes
// them, throttled by a credit window of outstanding writes.
module bp_cfg_init_loader
    import bp_common_cfg_pkg::*;
#(
    parameter bp_params_e bp_params_p   = e_bp_single_core_cfg,
    parameter int         max_credits_p = 4,
    localparam int        num_core      = cfg_num_core(bp_params_p),
    localparam int        core_id_width = (num_core > 1) ? $clog2(num_core) : 1,
    localparam int        credit_width  = $clog2(max_credits_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    output logic                     cfg_v_o,
    input  logic                     cfg_ready_i,
    output logic [core_id_width-1:0] cfg_core_o,
    output bp_cfg_reg_e              cfg_addr_o,
    output logic [15:0]              cfg_data_o,
    input  logic                     cfg_ack_v_i,
    output logic                     done_o,
    output logic                     err_o
);

    localparam logic [core_id_width-1:0] last_core  = core_id_width'(num_core - 1);
    localparam logic [credit_width-1:0]  full_count = credit_width'(max_credits_p);

    bp_cfg_loader_state_e     state_r;
    bp_cfg_loader_state_e     state_s;
    logic [core_id_width-1:0] core_r;
    logic [core_id_width-1:0] core_s;
    logic [1:0]               step_r;
    logic [1:0]               step_s;
    logic [credit_width-1:0]  credits_s;
    logic [credit_width-1:0]  credits_next_s;
    logic                     full_s;
    logic                     underflow_s;
    logic                     fire_s;
    logic                     v_s;
    logic [core_id_width-1:0] core_out_s;
    bp_cfg_reg_e              addr_s;
    logic [15:0]              data_s;

    assign fire_s = cfg_v_o & cfg_ready_i;

    bp_cfg_credit_counter #(.max_credits_p(max_credits_p)) u_credits (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .inc_i       (fire_s),
        .dec_i       (cfg_ack_v_i),
        .count_o     (credits_s),
        .full_o      (full_s),
        .underflow_o (underflow_s)
    );

    // Credit count after this edge; valid and the drain exit are decided from it.
    always_comb begin
        credits_next_s = credits_s;
        if (fire_s && !cfg_ack_v_i && !full_s) begin
            credits_next_s = credits_s + credit_width'(1);
        end else if (cfg_ack_v_i && !fire_s && (credits_s != '0)) begin
            credits_next_s = credits_s - credit_width'(1);
        end else begin
            credits_next_s = credits_s;
        end
    end

    // Sequencer: the pointer only advances when the presented write completes.
    always_comb begin
        state_s = state_r;
        core_s  = core_r;
        step_s  = step_r;
        case (state_r)
            e_idle: begin
                state_s = e_send_cfg;
                core_s  = '0;
                step_s  = 2'd0;
            end
            e_send_cfg: begin
                if (fire_s && (step_r == 2'd3)) begin
                    step_s = 2'd0;
                    if (core_r == last_core) begin
                        state_s = e_send_unfreeze;
                        core_s  = '0;
                    end else begin
                        core_s = core_r + core_id_width'(1);
                    end
                end else if (fire_s) begin
                    step_s = step_r + 2'd1;
                end else begin
                    step_s = step_r;
                end
            end
            e_send_unfreeze: begin
                if (fire_s && (core_r == last_core)) begin
                    state_s = e_drain;
                    core_s  = '0;
                end else if (fire_s) begin
                    core_s = core_r + core_id_width'(1);
                end else begin
                    core_s = core_r;
                end
            end
            e_drain: begin
                if (credits_next_s == '0) begin
                    state_s = e_done;
                end else begin
                    state_s = e_drain;
                end
            end
            e_done: begin
                state_s = e_done;
            end
            default: begin
                state_s = e_idle;
                core_s  = '0;
                step_s  = 2'd0;
            end
        endcase
    end

    // Payload for the write the next pointer selects; zero outside the send states.
    always_comb begin
        core_out_s = '0;
        addr_s     = e_cfg_freeze;
        data_s     = 16'h0000;
        v_s        = ((state_s == e_send_cfg) || (state_s == e_send_unfreeze))
                     && (credits_next_s != full_count);
        case (state_s)
            e_send_cfg: begin
                core_out_s = core_s;
                case (step_s)
                    2'd0: begin
                        addr_s = e_cfg_freeze;
                        data_s = 16'h0001;
                    end
                    2'd1: begin
                        addr_s = e_cfg_core_id;
                        data_s = 16'(core_s);
                    end
                    2'd2: begin
                        addr_s = e_cfg_cord;
                        data_s = cfg_cord_data(bp_params_p, int'(core_s));
                    end
                    default: begin
                        addr_s = e_cfg_domain;
                        data_s = 16'h0001;
                    end
                endcase
            end
            e_send_unfreeze: begin
                core_out_s = core_s;
                addr_s     = e_cfg_freeze;
                data_s     = 16'h0000;
            end
            default: begin
                core_out_s = '0;
            end
        endcase
    end

    // State, pointer and registered outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= e_idle;
            core_r     <= '0;
            step_r     <= 2'd0;
            cfg_v_o    <= 1'b0;
            cfg_core_o <= '0;
            cfg_addr_o <= e_cfg_freeze;
            cfg_data_o <= 16'h0000;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state_r    <= state_s;
            core_r     <= core_s;
            step_r     <= step_s;
            cfg_v_o    <= v_s;
            cfg_core_o <= core_out_s;
            cfg_addr_o <= addr_s;
            cfg_data_o <= data_s;
            done_o     <= (state_s == e_done);
            err_o      <= err_o | underflow_s;
        end
    end

endmodule

// File: tb/tb_bp_cfg_init_loader.sv
// Directed bench for the config loader: single-core and quad-core instances side by side.
module tb_bp_cfg_init_loader;
    import bp_common_cfg_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic        s_ready  = 1'b0;
    logic        s_auto   = 1'b0;
    logic        s_mack   = 1'b0;
    logic        s_fire_d = 1'b0;
    logic        s_ack;
    logic        s_v;
    logic        s_done;
    logic        s_err;
    logic [0:0]  s_core;
    bp_cfg_reg_e s_addr;
    logic [15:0] s_data;
    int          s_cnt = 0;
    logic [0:0]  s_core_log [64];
    logic [2:0]  s_addr_log [64];
    logic [15:0] s_data_log [64];
    int          s_cyc_log  [64];

    logic        q_ready  = 1'b1;
    logic        q_fire_d = 1'b0;
    logic        q_ack;
    logic        q_v;
    logic        q_done;
    logic        q_err;
    logic [1:0]  q_core;
    bp_cfg_reg_e q_addr;
    logic [15:0] q_data;
    int          q_cnt = 0;
    logic [1:0]  q_core_log [64];
    logic [2:0]  q_addr_log [64];
    logic [15:0] q_data_log [64];
    int          q_cyc_log  [64];

    logic [2:0]  s_exp_addr [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    logic [15:0] s_exp_data [5] = '{16'h0001, 16'h0000, 16'h0010, 16'h0001, 16'h0000};
    logic [15:0] q_cord     [4] = '{16'h0010, 16'h0011, 16'h0020, 16'h0021};

    assign s_ack = (s_auto & s_fire_d) | s_mack;
    assign q_ack = q_fire_d;

    bp_cfg_init_loader #(.bp_params_p(e_bp_single_core_cfg), .max_credits_p(4)) s_dut (
        .clk_i(clk), .reset_n_i(rst_n), .cfg_v_o(s_v), .cfg_ready_i(s_ready),
        .cfg_core_o(s_core), .cfg_addr_o(s_addr), .cfg_data_o(s_data),
        .cfg_ack_v_i(s_ack), .done_o(s_done), .err_o(s_err)
    );

    bp_cfg_init_loader #(.bp_params_p(e_bp_quad_core_cfg), .max_credits_p(4)) q_dut (
        .clk_i(clk), .reset_n_i(rst_n), .cfg_v_o(q_v), .cfg_ready_i(q_ready),
        .cfg_core_o(q_core), .cfg_addr_o(q_addr), .cfg_data_o(q_data),
        .cfg_ack_v_i(q_ack), .done_o(q_done), .err_o(q_err)
    );

    // Write logger and one-cycle-delayed ack source for both instances.
    always @(posedge clk) begin
        s_fire_d <= s_v & s_ready;
        q_fire_d <= q_v & q_ready;
        if (!rst_n) begin
            s_cnt <= 0;
            q_cnt <= 0;
        end else begin
            if (s_v && s_ready) begin
                if (s_cnt < 64) begin
                    s_core_log[s_cnt] <= s_core;
                    s_addr_log[s_cnt] <= s_addr;
                    s_data_log[s_cnt] <= s_data;
                    s_cyc_log[s_cnt]  <= cyc;
                end
                s_cnt <= s_cnt + 1;
            end
            if (q_v && q_ready) begin
                if (q_cnt < 64) begin
                    q_core_log[q_cnt] <= q_core;
                    q_addr_log[q_cnt] <= q_addr;
                    q_data_log[q_cnt] <= q_data;
                    q_cyc_log[q_cnt]  <= cyc;
                end
                q_cnt <= q_cnt + 1;
            end
        end
    end

    task automatic apply_reset(input logic s_auto_v, input logic s_ready_v);
        @(negedge clk);
        rst_n   = 1'b0;
        s_mack  = 1'b0;
        s_auto  = s_auto_v;
        s_ready = s_ready_v;
        q_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_single_seq(input string tag);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({s_core_log[i], s_addr_log[i], s_data_log[i]} !== {1'b0, s_exp_addr[i], s_exp_data[i]}) begin
                fails++;
                $display("FAIL %s[%0d] got core=%0d addr=%0d data=%h exp core=0 addr=%0d data=%h",
                         tag, i, s_core_log[i], s_addr_log[i], s_data_log[i], s_exp_addr[i], s_exp_data[i]);
            end
        end
    endtask

    task automatic test_reset;
        apply_reset(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_v, s_core, s_addr, s_data, s_done, s_err} !== 23'd0) begin
            fails++;
            $display("FAIL reset_async_s got v=%b core=%0d addr=%0d data=%h done=%b err=%b exp all 0",
                     s_v, s_core, s_addr, s_data, s_done, s_err);
        end
        checks++;
        if ({q_v, q_core, q_addr, q_data, q_done, q_err} !== 24'd0) begin
            fails++;
            $display("FAIL reset_async_q got v=%b core=%0d addr=%0d data=%h done=%b err=%b exp all 0",
                     q_v, q_core, q_addr, q_data, q_done, q_err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (s_v !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle_v got=%b exp=0", s_v);
        end
        @(negedge clk);
        checks++;
        if ({s_v, s_core, s_addr, s_data} !== {1'b1, 1'b0, 3'd0, 16'h0001}) begin
            fails++;
            $display("FAIL reset_first_write got v=%b core=%0d addr=%0d data=%h exp v=1 core=0 addr=0 data=0001",
                     s_v, s_core, s_addr, s_data);
        end
    endtask

    task automatic test_single_sequence;
        int n;
        apply_reset(1'b1, 1'b1);
        n = 0;
        while (s_cnt < 5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (s_cnt !== 5) begin
            fails++;
            $display("FAIL single_count got=%0d exp=5", s_cnt);
        end
        checks++;
        if (s_done !== 1'b0) begin
            fails++;
            $display("FAIL single_done_early got=%b exp=0", s_done);
        end
        @(negedge clk);
        checks++;
        if (s_done !== 1'b1) begin
            fails++;
            $display("FAIL single_done_after_ack got=%b exp=1", s_done);
        end
        check_single_seq("single_seq");
        checks++;
        if (s_cyc_log[4] - s_cyc_log[0] !== 4) begin
            fails++;
            $display("FAIL single_back_to_back got span=%0d exp=4", s_cyc_log[4] - s_cyc_log[0]);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({s_cnt, s_done, s_err, s_v} !== {32'd5, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL single_terminal got cnt=%0d done=%b err=%b v=%b exp cnt=5 done=1 err=0 v=0",
                     s_cnt, s_done, s_err, s_v);
        end
    endtask

    task automatic test_quad;
        int         n;
        logic [1:0] ec;
        logic [2:0] ea;
        logic [15:0] ed;
        apply_reset(1'b1, 1'b1);
        n = 0;
        while (!q_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({q_done, q_cnt} !== {1'b1, 32'd20}) begin
            fails++;
            $display("FAIL quad_done got done=%b cnt=%0d exp done=1 cnt=20", q_done, q_cnt);
        end
        for (int i = 0; i < 20; i++) begin
            if (i < 16) begin
                ec = 2'(i / 4);
                case (i % 4)
                    0:       begin ea = 3'd0; ed = 16'h0001; end
                    1:       begin ea = 3'd1; ed = 16'(ec); end
                    2:       begin ea = 3'd2; ed = q_cord[ec]; end
                    default: begin ea = 3'd3; ed = 16'h0001; end
                endcase
            end else begin
                ec = 2'(i - 16);
                ea = 3'd0;
                ed = 16'h0000;
            end
            checks++;
            if ({q_core_log[i], q_addr_log[i], q_data_log[i]} !== {ec, ea, ed}) begin
                fails++;
                $display("FAIL quad_seq[%0d] got core=%0d addr=%0d data=%h exp core=%0d addr=%0d data=%h",
                         i, q_core_log[i], q_addr_log[i], q_data_log[i], ec, ea, ed);
            end
        end
        checks++;
        if (q_data_log[14] !== 16'h0021) begin
            fails++;
            $display("FAIL quad_cord_core3 got=%h exp=0021", q_data_log[14]);
        end
        checks++;
        if (q_cyc_log[19] - q_cyc_log[0] !== 19) begin
            fails++;
            $display("FAIL quad_back_to_back got span=%0d exp=19", q_cyc_log[19] - q_cyc_log[0]);
        end
    endtask

    task automatic test_credits;
        apply_reset(1'b0, 1'b1);
        repeat (10) @(negedge clk);
        checks++;
        if ({s_cnt, s_v} !== {32'd4, 1'b0}) begin
            fails++;
            $display("FAIL credits_full got cnt=%0d v=%b exp cnt=4 v=0", s_cnt, s_v);
        end
        s_mack = 1'b1;
        @(negedge clk);
        s_mack = 1'b0;
        checks++;
        if (s_v !== 1'b1) begin
            fails++;
            $display("FAIL credits_v_after_ack got=%b exp=1", s_v);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({s_cnt, s_v, s_done} !== {32'd5, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL credits_one_more got cnt=%0d v=%b done=%b exp cnt=5 v=0 done=0", s_cnt, s_v, s_done);
        end
        repeat (4) begin
            s_mack = 1'b1;
            @(negedge clk);
        end
        s_mack = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_done, s_err, s_cnt} !== {1'b1, 1'b0, 32'd5}) begin
            fails++;
            $display("FAIL credits_drain got done=%b err=%b cnt=%0d exp done=1 err=0 cnt=5", s_done, s_err, s_cnt);
        end
    endtask

    task automatic test_random_ready;
        int          n;
        int          stalls;
        logic        prev_stall;
        logic [20:0] prev;
        apply_reset(1'b1, 1'b0);
        n          = 0;
        stalls     = 0;
        prev_stall = 1'b0;
        prev       = '0;
        while (!s_done && n < 300) begin
            @(negedge clk);
            n++;
            if (prev_stall) begin
                stalls++;
                checks++;
                if ({s_v, s_core, s_addr, s_data} !== prev) begin
                    fails++;
                    $display("FAIL stall_stable got=%h exp=%h", {s_v, s_core, s_addr, s_data}, prev);
                end
            end
            s_ready    = 1'($urandom_range(0, 1));
            prev       = {s_v, s_core, s_addr, s_data};
            prev_stall = s_v & ~s_ready;
        end
        s_ready = 1'b1;
        checks++;
        if ({s_done, s_cnt} !== {1'b1, 32'd5}) begin
            fails++;
            $display("FAIL random_done got done=%b cnt=%0d exp done=1 cnt=5", s_done, s_cnt);
        end
        check_single_seq("random_seq");
    endtask

    task automatic test_spurious_ack;
        int n;
        apply_reset(1'b0, 1'b0);
        @(negedge clk);
        s_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_dut.u_credits.count_o, s_cnt} !== {3'd1, 32'd1}) begin
            fails++;
            $display("FAIL sim_setup got credits=%0d cnt=%0d exp credits=1 cnt=1", s_dut.u_credits.count_o, s_cnt);
        end
        s_mack = 1'b1;
        @(negedge clk);
        s_ready = 1'b0;
        checks++;
        if ({s_dut.u_credits.count_o, s_cnt, s_err} !== {3'd1, 32'd2, 1'b0}) begin
            fails++;
            $display("FAIL sim_write_ack got credits=%0d cnt=%0d err=%b exp credits=1 cnt=2 err=0",
                     s_dut.u_credits.count_o, s_cnt, s_err);
        end
        repeat (2) @(negedge clk);
        s_mack = 1'b0;
        checks++;
        if (s_err !== 1'b1) begin
            fails++;
            $display("FAIL spurious_err got=%b exp=1", s_err);
        end
        s_auto  = 1'b1;
        s_ready = 1'b1;
        n = 0;
        while (!s_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({s_done, s_err, s_cnt} !== {1'b1, 1'b1, 32'd5}) begin
            fails++;
            $display("FAIL spurious_complete got done=%b err=%b cnt=%0d exp done=1 err=1 cnt=5", s_done, s_err, s_cnt);
        end
        check_single_seq("spurious_seq");
    endtask

    task automatic test_reset_midway;
        int n;
        apply_reset(1'b1, 1'b1);
        n = 0;
        while (q_cnt < 5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({q_v, q_core} !== {1'b1, 2'd1}) begin
            fails++;
            $display("FAIL mid_core1 got v=%b core=%0d exp v=1 core=1", q_v, q_core);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({q_v, q_core, q_addr, q_data, q_done, q_err} !== 24'd0) begin
            fails++;
            $display("FAIL mid_reset_outputs got v=%b core=%0d addr=%0d data=%h done=%b err=%b exp all 0",
                     q_v, q_core, q_addr, q_data, q_done, q_err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!q_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({q_core_log[0], q_addr_log[0], q_data_log[0]} !== {2'd0, 3'd0, 16'h0001}) begin
            fails++;
            $display("FAIL mid_restart got core=%0d addr=%0d data=%h exp core=0 addr=0 data=0001",
                     q_core_log[0], q_addr_log[0], q_data_log[0]);
        end
        checks++;
        if ({q_done, q_cnt} !== {1'b1, 32'd20}) begin
            fails++;
            $display("FAIL mid_complete got done=%b cnt=%0d exp done=1 cnt=20", q_done, q_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_single_sequence;
        test_quad;
        test_credits;
        test_random_ready;
        test_spurious_ack;
        test_reset_midway;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
